mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates the single unified main-memory port between the instruction-cache fill path (read-only) and the data-cache fill/writeback path (read/write). Sits between the IF-stage and MEM-stage cache controllers and main memory. Grants one transaction at a time, holds it until memory completes or a watchdog expires, and returns data and an ack pulse to the winner. Round-robin fairness applies when both sides request simultaneously.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 64, cache-line transfer width
TIMEOUT, 32, max cycles waiting for mem_ready before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_req  in  1  icache read request, level, held until i_ack
i_addr  in  ADDR_W  icache line address
i_ack  out  1  one-cycle completion pulse to icache
i_rdata  out  DATA_W  line data, valid while i_ack=1
d_req  in  1  dcache request, level, held until d_ack
d_we  in  1  1=write(writeback), 0=read(fill)
d_addr  in  ADDR_W  dcache line address
d_wdata  in  DATA_W  writeback data
d_ack  out  1  one-cycle completion pulse to dcache
d_rdata  out  DATA_W  read data, valid while d_ack=1
mem_valid  out  1  request to memory, held until mem_ready
mem_we  out  1  write strobe to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion, single cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
busy  out  1  high whenever state != IDLE
owner_d  out  1  1=current/last grant is dcache
err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state=IDLE; all outputs 0 (i_ack, d_ack, i_rdata, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy, err); last-grant pointer = icache (so dcache wins the first tie); watchdog=0.
- States: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE: if only one req high, grant it; if both high, grant the side not granted last; if none, stay. On grant, register owner, address, we (icache forces we=0), wdata; enter ISSUE. mem_valid rises the cycle after req is first sampled.
- ISSUE: mem_valid=1, mem_addr/we/wdata stable (latched, unaffected by requester input changes). Watchdog increments each cycle. On mem_ready=1: capture mem_rdata into owner's rdata register, go RESP. If watchdog reaches TIMEOUT-1 without mem_ready: drop mem_valid, pulse err, go RESP with rdata=0.
- RESP: exactly one cycle; owner's ack=1, rdata valid; other ack=0; mem_valid=0; update last-grant pointer; clear watchdog; go IDLE.
- Ack is also asserted on timeout; err distinguishes aborted transactions.
- Requester must drop req the cycle after ack; req still high in the IDLE cycle after RESP is treated as a new request.
- Minimum transaction is 3 cycles (IDLE grant, ISSUE with same-cycle-next mem_ready, RESP); back-to-back grant possible in the IDLE cycle after RESP.
- mem_ready while not in ISSUE: ignored.
- Non-owner rdata holds its previous value; it is only meaningful with its ack.
- rst asserted mid-transaction: immediate return to reset values next edge; no ack or err is issued for the aborted transaction; mem_valid drops.
- busy=1 in ISSUE and RESP; owner_d holds the last grant in IDLE.

Test Plan:
- Single icache read: i_req=1, i_addr=0x0040; mem_ready after 3 ISSUE cycles with rdata=0x1122334455667788 -> mem_valid 1 cycle after req, mem_we=0, mem_addr=0x0040, i_ack pulse 1 cycle after mem_ready, i_rdata=0x1122334455667788, d_ack stays 0.
- Dcache writeback: d_req=1, d_we=1, d_addr=0x8000, d_wdata=0xDEADBEEFCAFEF00D -> mem_we=1, mem_wdata matches; d_wdata changes during ISSUE do not alter mem_wdata; d_ack after mem_ready.
- Simultaneous requests out of reset, both held high -> dcache granted first, icache second; with both re-requesting continuously, grants alternate D,I,D,I.
- Watchdog: d_req=1, mem_ready never asserts, TIMEOUT=32 -> mem_valid high 32 cycles then low, err and d_ack pulse together, d_rdata=0, and the next pending request is granted.
- Reset mid-ISSUE: assert rst 2 cycles into ISSUE -> next cycle mem_valid=0, busy=0, no ack/err; after release with both reqs high, dcache wins.
- Stray mem_ready in IDLE with no requests -> no ack, state stays IDLE, rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single main-memory port between the icache fill path
//            (read-only) and the dcache fill/writeback path (read/write).
//            One transaction at a time: IDLE (arbitrate) -> ISSUE (drive
//            memory until mem_ready or watchdog expiry) -> RESP (one-cycle
//            ack to the winner). Ties are broken round-robin.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            i_req/i_addr          - icache request (level, held until i_ack)
//            i_ack/i_rdata         - icache completion pulse and line data
//            d_req/d_we/d_addr/
//            d_wdata               - dcache request, direction, address, data
//            d_ack/d_rdata         - dcache completion pulse and read data
//            mem_valid/mem_we/
//            mem_addr/mem_wdata    - request to main memory (latched)
//            mem_ready/mem_rdata   - memory completion and read data
//            busy                  - transaction in flight (ISSUE or RESP)
//            owner_d               - current/last grant went to dcache
//            err                   - pulses with the ack of an aborted access
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_d,
  output logic              err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q;    // 1 = dcache owns the current/last grant
  logic              last_d_q;   // round-robin pointer, updated at completion
  logic              we_q;
  logic              abort_q;    // current transaction ended by the watchdog
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [WD_W-1:0]   wd_q;

  logic w_grant_d;
  logic w_timeout;

  // On a tie the side that did not win last time is granted.
  assign w_grant_d = d_req & (~i_req | ~last_d_q);

  // mem_ready has priority over the watchdog in the final ISSUE cycle.
  assign w_timeout = (state_q == S_ISSUE) && !mem_ready && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req || d_req) state_d = S_ISSUE;
      S_ISSUE: if (mem_ready || w_timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_d_q  <= 1'b0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner_q <= w_grant_d;
            addr_q  <= w_grant_d ? d_addr : i_addr;
            we_q    <= w_grant_d & d_we;
            wdata_q <= w_grant_d ? d_wdata : '0;
            abort_q <= 1'b0;
            wd_q    <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            if (owner_q) d_rdata_q <= mem_rdata;
            else         i_rdata_q <= mem_rdata;
          end else if (w_timeout) begin
            abort_q <= 1'b1;
            if (owner_q) d_rdata_q <= '0;
            else         i_rdata_q <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP: begin
          last_d_q <= owner_q;
          wd_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (state_q == S_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner_d   = owner_q;
  assign i_ack     = (state_q == S_RESP) && !owner_q;
  assign d_ack     = (state_q == S_RESP) &&  owner_q;
  assign err       = (state_q == S_RESP) &&  abort_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized self-checking bench for mem_arbiter. A transaction-
//            level reference model (who is served, for how long memory has
//            been asked, what each requester gets back) predicts every
//            output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner_d;
  logic              err;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner_d(owner_d), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a transaction in flight, how many cycles memory has
  // been asked, whether the answer is being returned this cycle.
  bit              m_act, m_resp, m_err, m_own, m_last, m_we;
  int              m_wait;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_ir, m_dr;

  // Stimulus knobs
  int req_pct, ready_pct, rst_pct;
  bit keep_high;
  int n_timeouts, n_grants_d, n_grants_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_resp = 0; m_err = 0; m_own = 0; m_last = 0; m_we = 0;
    m_wait = 0; m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
  endtask

  // Advance the model across one clock edge using the inputs seen at it.
  task automatic model_edge();
    bit gd;
    if (rst) begin
      model_reset();
    end else if (!m_act) begin
      if (i_req || d_req) begin
        gd      = (i_req && d_req) ? !m_last : d_req;
        m_act   = 1; m_resp = 0; m_err = 0; m_wait = 0;
        m_own   = gd;
        m_addr  = gd ? d_addr : i_addr;
        m_we    = gd && d_we;
        m_wdata = gd ? d_wdata : '0;
        if (gd) n_grants_d++; else n_grants_i++;
      end
    end else if (!m_resp) begin
      m_wait++;
      if (mem_ready) begin
        m_resp = 1; m_err = 0;
        if (m_own) m_dr = mem_rdata; else m_ir = mem_rdata;
      end else if (m_wait == TIMEOUT) begin
        m_resp = 1; m_err = 1; n_timeouts++;
        if (m_own) m_dr = '0; else m_ir = '0;
      end
    end else begin
      m_act = 0; m_resp = 0; m_err = 0;
      m_last = m_own;
    end
  endtask

  task automatic check_outputs();
    chk("busy",      busy,      m_act);
    chk("mem_valid", mem_valid, m_act && !m_resp);
    chk("i_ack",     i_ack,     m_resp && !m_own);
    chk("d_ack",     d_ack,     m_resp && m_own);
    chk("err",       err,       m_resp && m_err);
    chk("owner_d",   owner_d,   m_own);
    chk("i_rdata",   i_rdata,   m_ir);
    chk("d_rdata",   d_rdata,   m_dr);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_we",    mem_we,    m_we);
    if (m_act && !m_resp && m_we)
      chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  // Choose inputs for the next cycle from what was just observed.
  task automatic drive_next();
    bit ack_i, ack_d;
    ack_i = m_resp && !m_own;
    ack_d = m_resp &&  m_own;
    if (keep_high) begin
      i_req = 1; d_req = 1;
    end else begin
      if (i_req && ack_i) i_req = 0;
      else if (!i_req && ($urandom_range(0, 99) < req_pct)) i_req = 1;
      if (d_req && ack_d) d_req = 0;
      else if (!d_req && ($urandom_range(0, 99) < req_pct)) d_req = 1;
    end
    // Requester-side fields churn every cycle; only grant-time values count.
    i_addr    = ADDR_W'($urandom);
    d_addr    = ADDR_W'($urandom);
    d_we      = 1'($urandom);
    d_wdata   = {$urandom, $urandom};
    mem_rdata = {$urandom, $urandom};
    if (m_act && !m_resp) mem_ready = ($urandom_range(0, 99) < ready_pct);
    else                  mem_ready = ($urandom_range(0, 9) == 0);  // stray
    rst = ($urandom_range(0, 99) < rst_pct);
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      drive_next();
    end
  endtask

  initial begin
    rst = 1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    req_pct = 0; ready_pct = 0; rst_pct = 0; keep_high = 0;
    n_timeouts = 0; n_grants_d = 0; n_grants_i = 0;
    model_reset();

    // Reset state, with a stray mem_ready while held in reset.
    @(posedge clk); model_edge(); #1; check_outputs();
    mem_ready = 1; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    @(posedge clk); model_edge(); #1; check_outputs();

    // Idle with stray mem_ready: nothing must happen.
    rst = 0;
    run_cycles(20);

    // Mixed traffic, responsive memory.
    req_pct = 30; ready_pct = 40;
    run_cycles(400);

    // Both sides requesting continuously: grants must alternate.
    keep_high = 1; ready_pct = 50;
    run_cycles(200);
    keep_high = 0; i_req = 0; d_req = 0;
    run_cycles(60);

    // Sluggish memory: watchdog aborts.
    req_pct = 50; ready_pct = 2;
    run_cycles(800);

    // Random resets in the middle of traffic.
    req_pct = 40; ready_pct = 30; rst_pct = 3;
    run_cycles(600);
    rst_pct = 0;
    run_cycles(100);

    chk("timeouts_seen", (n_timeouts > 0), 1'b1);
    chk("both_sides_served", (n_grants_d > 0) && (n_grants_i > 0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
